// File: rtl/sound_pkg.sv
// Shared constants for the buzzer scheduler: note half-periods (50 MHz clock),
// source IDs, melody lengths and the scheduler state encoding.
package sound_pkg;

  localparam int unsigned SRC_W = 2;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned REQ_W = 3;

  // Half-period constants in clock cycles; REST silences the tone generator.
  localparam int unsigned L5   = 63776;
  localparam int unsigned M1   = 47774;
  localparam int unsigned M3   = 37919;
  localparam int unsigned M5   = 31888;
  localparam int unsigned REST = 0;

  localparam logic [SRC_W-1:0] CLICK   = 2'd0;
  localparam logic [SRC_W-1:0] SUCCESS = 2'd1;
  localparam logic [SRC_W-1:0] ERROR   = 2'd2;

  localparam int unsigned LEN_CLICK   = 1;
  localparam int unsigned LEN_SUCCESS = 18;
  localparam int unsigned LEN_ERROR   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Number of notes in the melody of a source.
  function automatic logic [IDX_W-1:0] melody_len(input logic [SRC_W-1:0] src);
    logic [IDX_W-1:0] len;
    case (src)
      SUCCESS: len = IDX_W'(LEN_SUCCESS);
      ERROR:   len = IDX_W'(LEN_ERROR);
      default: len = IDX_W'(LEN_CLICK);
    endcase
    return len;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator with phase restart.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_half         : half-period in clock cycles (0 = rest, output held low)
//   i_load         : pulse on the edge a new half-period is applied; restarts phase
//   o_beep         : square-wave output
module tone_gen #(
  parameter int unsigned HP_W = 17
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [HP_W-1:0] i_half,
  input  logic            i_load,
  output logic            o_beep
);

  logic [HP_W-1:0] r_cnt;
  logic            r_beep;

  // Counter runs 0..half-1 and flips the output at the top of each half-period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_beep <= 1'b0;
    end else if (i_load || (i_half == '0)) begin
      r_cnt  <= '0;
      r_beep <= 1'b0;
    end else if (r_cnt == (i_half - HP_W'(1))) begin
      r_cnt  <= '0;
      r_beep <= ~r_beep;
    end else begin
      r_cnt  <= r_cnt + HP_W'(1);
    end
  end

  assign o_beep = r_beep;

endmodule

// File: rtl/sound_scheduler.sv
// Buzzer arbiter and melody sequencer for click / success / error sounds.
// Latches one-cycle requests, serves them by fixed priority (error > success >
// click), steps the granted melody at NOTE_TICKS cycles per note and drives a
// square-wave tone generator.
// Optional feature: define SOUND_PREEMPT_EN to let a higher-priority request
// cut the current melody short (dropped, no o_done, not re-queued).
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_req[2:0]      : request pulses (0 click, 1 success, 2 error)
//   i_enable        : low aborts playback and flushes pending requests
//   o_beep          : buzzer drive
//   o_busy          : high in LOAD, PLAY, DONE
//   o_grant         : source being played (0 when idle)
//   o_done          : one-cycle pulse on normal melody completion
//   o_half_period   : current note half-period (0 = rest / idle)
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int unsigned NOTE_TICKS = 12500000,
  parameter int unsigned HP_W       = 17
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [REQ_W-1:0] i_req,
  input  logic             i_enable,
  output logic             o_beep,
  output logic             o_busy,
  output logic [SRC_W-1:0] o_grant,
  output logic             o_done,
  output logic [HP_W-1:0]  o_half_period
);

  localparam int unsigned TICK_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(NOTE_TICKS - 1);

  // Melody ROM: half-period of note idx of the given source.
  function automatic logic [HP_W-1:0] note_rom(input logic [SRC_W-1:0] src,
                                               input logic [IDX_W-1:0] idx);
    int unsigned hp;
    hp = REST;
    case (src)
      CLICK: hp = M5;
      SUCCESS: begin
        case (idx)
          5'd0, 5'd5, 5'd6, 5'd9, 5'd10, 5'd14:  hp = M1;
          5'd1, 5'd2, 5'd7, 5'd11, 5'd12, 5'd15: hp = M3;
          5'd3, 5'd4, 5'd8, 5'd13, 5'd16, 5'd17: hp = M5;
          default:                               hp = REST;
        endcase
      end
      ERROR: hp = idx[0] ? REST : L5;
      default: hp = REST;
    endcase
    return HP_W'(hp);
  endfunction

  state_e             r_state, w_state_nxt;
  logic [REQ_W-1:0]   r_pend, w_clr;
  logic [SRC_W-1:0]   r_grant, w_grant_nxt, w_sel;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [TICK_W-1:0]  r_tick, w_tick_nxt;
  logic [HP_W-1:0]    r_half, w_half_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               w_load, w_preempt, w_note_end, w_last;

  assign w_sel      = r_pend[2] ? ERROR : (r_pend[1] ? SUCCESS : CLICK);
  assign w_note_end = (r_tick == TICK_LAST);
  assign w_last     = (r_idx == (melody_len(r_grant) - IDX_W'(1)));

`ifdef SOUND_PREEMPT_EN
  // A pending source strictly above the one playing.
  assign w_preempt = (r_grant == CLICK)   ? (|r_pend[2:1]) :
                     (r_grant == SUCCESS) ? r_pend[2] : 1'b0;
`else
  assign w_preempt = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; a low enable overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (|r_pend) w_state_nxt = ST_LOAD;
        ST_LOAD: w_state_nxt = ST_PLAY;
        ST_PLAY: begin
          if (w_preempt)                 w_state_nxt = ST_LOAD;
          else if (w_note_end && w_last) w_state_nxt = ST_DONE;
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output/datapath next values. Grant is latched on entry to LOAD so it is
  // visible together with o_busy; the pend bit is cleared on that same edge.
  always_comb begin
    w_grant_nxt = r_grant;
    w_idx_nxt   = r_idx;
    w_tick_nxt  = r_tick;
    w_half_nxt  = r_half;
    w_load      = 1'b0;
    w_clr       = '0;
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_done_nxt  = (r_state == ST_PLAY) && (w_state_nxt == ST_DONE);
    if (!i_enable) begin
      w_grant_nxt = '0;
      w_idx_nxt   = '0;
      w_tick_nxt  = '0;
      w_half_nxt  = '0;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_state_nxt == ST_LOAD) begin
            w_grant_nxt = w_sel;
            w_clr       = 3'b001 << w_sel;
            w_idx_nxt   = '0;
            w_tick_nxt  = '0;
          end
        end
        ST_LOAD: begin
          w_idx_nxt  = '0;
          w_tick_nxt = '0;
          w_half_nxt = note_rom(r_grant, IDX_W'(0));
          w_load     = 1'b1;
        end
        ST_PLAY: begin
          if (w_state_nxt == ST_LOAD) begin
            w_grant_nxt = w_sel;
            w_clr       = 3'b001 << w_sel;
            w_idx_nxt   = '0;
            w_tick_nxt  = '0;
            w_half_nxt  = '0;
            w_load      = 1'b1;
          end else if (w_note_end) begin
            w_tick_nxt = '0;
            w_load     = 1'b1;
            if (w_state_nxt == ST_DONE) begin
              w_half_nxt = '0;
            end else begin
              w_idx_nxt  = r_idx + IDX_W'(1);
              w_half_nxt = note_rom(r_grant, r_idx + IDX_W'(1));
            end
          end else begin
            w_tick_nxt = r_tick + TICK_W'(1);
          end
        end
        ST_DONE: w_grant_nxt = '0;
        default: w_grant_nxt = '0;
      endcase
    end
  end

  // Datapath registers. A request on the clearing edge re-arms its pend bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend  <= '0;
      r_grant <= '0;
      r_idx   <= '0;
      r_tick  <= '0;
      r_half  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_pend  <= i_enable ? ((r_pend & ~w_clr) | i_req) : '0;
      r_grant <= w_grant_nxt;
      r_idx   <= w_idx_nxt;
      r_tick  <= w_tick_nxt;
      r_half  <= w_half_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  tone_gen #(.HP_W(HP_W)) u_tone (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_half  (r_half),
    .i_load  (w_load),
    .o_beep  (o_beep)
  );

  assign o_busy        = r_busy;
  assign o_grant       = r_grant;
  assign o_done        = r_done;
  assign o_half_period = r_half;

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed self-checking bench for sound_scheduler (NOTE_TICKS = 4) plus a
// stand-alone tone_gen instance with a short half-period to observe toggling.
module tb_sound_scheduler;

  logic        clk;
  logic        rst_n;
  logic [2:0]  i_req;
  logic        i_enable;
  logic        o_beep;
  logic        o_busy;
  logic [1:0]  o_grant;
  logic        o_done;
  logic [16:0] o_half_period;

  logic [16:0] tg_half;
  logic        tg_load;
  logic        tg_beep;

  int n_checks;
  int n_fail;

  int succ_notes[18] = '{47774, 37919, 37919, 31888, 31888, 47774, 47774, 37919, 31888,
                         47774, 47774, 37919, 37919, 31888, 47774, 37919, 31888, 31888};

  sound_scheduler #(.NOTE_TICKS(4), .HP_W(17)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req         (i_req),
    .i_enable      (i_enable),
    .o_beep        (o_beep),
    .o_busy        (o_busy),
    .o_grant       (o_grant),
    .o_done        (o_done),
    .o_half_period (o_half_period)
  );

  tone_gen #(.HP_W(17)) u_tg (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_half  (tg_half),
    .i_load  (tg_load),
    .o_beep  (tg_beep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_note(input int src, input int i);
    if (src == 0) return 31888;
    if (src == 1) return succ_notes[i];
    return ((i % 2) == 1) ? 0 : 63776;
  endfunction

  function automatic int exp_len(input int src);
    if (src == 0) return 1;
    if (src == 1) return 18;
    return 4;
  endfunction

  // Entered at the sample point right after the edge into LOAD. Optionally
  // injects inj_req for one cycle at the start of note inj_note.
  task automatic run_melody(input int src, input int inj_note, input logic [2:0] inj_req);
    chk("load_busy", 32'(o_busy), 32'd1);
    chk("load_grant", 32'(o_grant), 32'(src));
    chk("load_half", 32'(o_half_period), 32'd0);
    for (int i = 0; i < exp_len(src); i++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("note_half", 32'(o_half_period), 32'(exp_note(src, i)));
        chk("note_busy", 32'(o_busy), 32'd1);
        chk("note_done", 32'(o_done), 32'd0);
        chk("note_beep", 32'(o_beep), 32'd0);
        if (i == inj_note && c == 0) i_req = inj_req;
        else                         i_req = 3'b000;
`ifdef SOUND_PREEMPT_EN
        if (i == inj_note && c == 1 && inj_req[2] && src != 2) begin
          @(negedge clk);
          chk("preempt_grant", 32'(o_grant), 32'd2);
          chk("preempt_busy", 32'(o_busy), 32'd1);
          chk("preempt_half", 32'(o_half_period), 32'd0);
          chk("preempt_done", 32'(o_done), 32'd0);
          return;
        end
`endif
      end
    end
    @(negedge clk);
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("done_busy", 32'(o_busy), 32'd1);
    chk("done_half", 32'(o_half_period), 32'd0);
    @(negedge clk);
    chk("idle_done", 32'(o_done), 32'd0);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_grant", 32'(o_grant), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    i_enable = 1'b1;
    i_req    = 3'b000;
    tg_half  = '0;
    tg_load  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_half", 32'(o_half_period), 32'd0);
    chk("rst_beep", 32'(o_beep), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(o_busy), 32'd0);

    // Click, with a repeat click queued while it plays
    i_req = 3'b001;
    @(negedge clk);
    i_req = 3'b000;
    chk("click_req_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    run_melody(0, 0, 3'b001);
    @(negedge clk);
    run_melody(0, -1, 3'b000);
    @(negedge clk);
    chk("click_end_busy", 32'(o_busy), 32'd0);

    // Success jingle
    i_req = 3'b010;
    @(negedge clk);
    i_req = 3'b000;
    @(negedge clk);
    run_melody(1, -1, 3'b000);

    // Simultaneous requests: error, success, click
    i_req = 3'b111;
    @(negedge clk);
    i_req = 3'b000;
    chk("sim_req_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    run_melody(2, -1, 3'b000);
    @(negedge clk);
    run_melody(1, -1, 3'b000);
    @(negedge clk);
    run_melody(0, -1, 3'b000);
    repeat (3) begin
      @(negedge clk);
      chk("sim_after_busy", 32'(o_busy), 32'd0);
      chk("sim_after_done", 32'(o_done), 32'd0);
    end

    // Error request during success note 3
    i_req = 3'b010;
    @(negedge clk);
    i_req = 3'b000;
    @(negedge clk);
    run_melody(1, 2, 3'b100);
`ifndef SOUND_PREEMPT_EN
    @(negedge clk);
`endif
    run_melody(2, -1, 3'b000);
    repeat (2) begin
      @(negedge clk);
      chk("pre_after_busy", 32'(o_busy), 32'd0);
    end

    // Abort mid-play with a click pending
    i_req = 3'b010;
    @(negedge clk);
    i_req = 3'b000;
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("abort_mid_half", 32'(o_half_period), 32'd37919);
    i_req = 3'b001;
    @(negedge clk);
    i_req    = 3'b000;
    i_enable = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_grant", 32'(o_grant), 32'd0);
    chk("abort_half", 32'(o_half_period), 32'd0);
    chk("abort_beep", 32'(o_beep), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    i_enable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_flushed_busy", 32'(o_busy), 32'd0);
    end

    // Asynchronous reset mid-play
    i_req = 3'b010;
    @(negedge clk);
    i_req = 3'b000;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_half_before", 32'(o_half_period), 32'd47774);
    chk("rstmid_grant_before", 32'(o_grant), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(o_busy), 32'd0);
    chk("rstmid_grant", 32'(o_grant), 32'd0);
    chk("rstmid_half", 32'(o_half_period), 32'd0);
    chk("rstmid_done", 32'(o_done), 32'd0);
    chk("rstmid_beep", 32'(o_beep), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_after_busy", 32'(o_busy), 32'd0);

    // Tone generator: half-period 3 toggles every 3 cycles, then rest forces 0
    tg_half = 17'd3;
    tg_load = 1'b1;
    @(negedge clk);
    tg_load = 1'b0;
    for (int n = 0; n < 5; n++) begin
      chk("tg_beep", 32'(tg_beep), 32'((n / 3) % 2));
      @(negedge clk);
    end
    chk("tg_beep_n5", 32'(tg_beep), 32'd1);
    tg_half = 17'd0;
    @(negedge clk);
    chk("tg_rest_beep", 32'(tg_beep), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
